// File: rtl/rv_skid_pkg.sv
// Shared types and helpers for the rv_skid valid/ready skid buffer.
package rv_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Bypass mode only ever holds the skid entry, so FULL means one entry there.
    function automatic logic [1:0] skid_count(skid_state_e state, bit reg_out);
        case (state)
            BUSY:    skid_count = 2'd1;
            FULL:    skid_count = reg_out ? 2'd2 : 2'd1;
            default: skid_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rv_skid_reg.sv
// Payload register with load enable; clears to zero on reset only.
module skid_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   data_q <= '0;
        else if (en_i) data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/rv_skid.sv
// Two-entry valid/ready skid buffer; REG_OUT picks registered-output or bypass variant.
module rv_skid #(
    parameter int DATA_W  = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    import rv_skid_pkg::*;

    skid_state_e       state_q, state_d;
    logic              in_ready_q;
    logic              skid_en;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;

    assign in_fire = in_valid & in_ready_q;

    skid_reg #(.DATA_W(DATA_W)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (skid_en),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    if (REG_OUT) begin : g_reg
        logic              main_en;
        logic [DATA_W-1:0] main_d, main_q;
        logic              out_fire;

        assign out_fire = (state_q != EMPTY) & out_ready;

        always_comb begin
            state_d = state_q;
            main_en = 1'b0;
            skid_en = 1'b0;
            if (flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: if (in_fire) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            main_en = 1'b1;
                        end else if (in_fire) begin
                            skid_en = 1'b1;
                            state_d = FULL;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: if (out_fire) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        // Draining from FULL promotes the skid entry; otherwise main takes the input.
        assign main_d = (state_q == FULL) ? skid_q : in_data;

        skid_reg #(.DATA_W(DATA_W)) u_main (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (main_en),
            .d_i    (main_d),
            .q_o    (main_q)
        );

        assign out_valid = (state_q != EMPTY);
        assign out_data  = main_q;
    end else begin : g_byp
        always_comb begin
            state_d = state_q;
            skid_en = 1'b0;
            if (flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    // Data only parks in the skid register when the consumer stalls.
                    EMPTY: if (in_fire && !out_ready) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end
                    FULL: if (out_ready) state_d = EMPTY;
                    default: state_d = EMPTY;
                endcase
            end
        end

        assign out_valid = in_valid | (state_q == FULL);
        assign out_data  = (state_q == FULL) ? skid_q : in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign in_ready = in_ready_q;
    assign count    = skid_count(state_q, REG_OUT);

endmodule

// File: tb/tb_rv_skid.sv
// Bench for rv_skid: both modes side by side at DATA_W=32 against a queue model.
module tb_rv_skid;
    localparam int W = 32;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
    logic iv0 = 1'b0, or0 = 1'b0, ir0, ov0;
    logic [W-1:0] id1 = '0, id0 = '0, od1, od0;
    logic [1:0] cnt1, cnt0;
    int total = 0, bad = 0;
    logic [W-1:0] q1[$], q0[$];
    bit acc1;

    always #5 clk = ~clk;

    rv_skid #(.DATA_W(W), .REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1));

    rv_skid #(.DATA_W(W), .REG_OUT(1'b0)) dut_byp (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(cnt0));

    // Scoreboard: accepted entries are pushed, delivered entries popped.
    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            acc1 = iv1 && (q1.size() < 2);
            if (q1.size() > 0 && or1) void'(q1.pop_front());
            if (acc1) q1.push_back(id1);
            if (q0.size() > 0) begin
                if (or0) void'(q0.pop_front());
            end else if (iv0 && !or0) begin
                q0.push_back(id0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_ready_reg got=%b want=1", ir1); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_valid_reg got=%b want=0", ov1); end
        total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL reset_count_reg got=%0d want=0", cnt1); end
        total++; if (od1 !== '0) begin bad++; $display("FAIL reset_data_reg got=%h want=0", od1); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_ready_byp got=%b want=1", ir0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_valid_byp got=%b want=0", ov0); end
        total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL reset_count_byp got=%0d want=0", cnt0); end
        tick;
        rst = 1'b1;
    endtask

    task automatic test_stream;
        or1 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            iv1 = 1'b1; id1 = W'(i);
            tick;
            total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL stream_valid i=%0d got=%b want=1", i, ov1); end
            total++; if (od1 !== W'(i)) begin bad++; $display("FAIL stream_data got=%h want=%h", od1, W'(i)); end
            total++; if (cnt1 !== 2'd1) begin bad++; $display("FAIL stream_count i=%0d got=%0d want=1", i, cnt1); end
            total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b want=1", i, ir1); end
        end
        iv1 = 1'b0;
        tick;
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b want=0", ov1); end
        total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL stream_drain_count got=%0d want=0", cnt1); end
        or1 = 1'b0;
    endtask

    task automatic test_backpressure;
        or1 = 1'b0; iv1 = 1'b1; id1 = 32'hA5;
        tick;
        total++; if (cnt1 !== 2'd1) begin bad++; $display("FAIL bp_count1 got=%0d want=1", cnt1); end
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", ir1); end
        id1 = 32'h5A;
        tick;
        iv1 = 1'b0;
        total++; if (cnt1 !== 2'd2) begin bad++; $display("FAIL bp_count2 got=%0d want=2", cnt1); end
        total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", ir1); end
        total++; if (od1 !== 32'hA5) begin bad++; $display("FAIL bp_head got=%h want=a5", od1); end
        or1 = 1'b1;
        tick;
        total++; if (od1 !== 32'h5A) begin bad++; $display("FAIL bp_second got=%h want=5a", od1); end
        total++; if (cnt1 !== 2'd1) begin bad++; $display("FAIL bp_count_drain got=%0d want=1", cnt1); end
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", ir1); end
        tick;
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL bp_empty_valid got=%b want=0", ov1); end
        total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL bp_empty_count got=%0d want=0", cnt1); end
        or1 = 1'b0;
    endtask

    task automatic test_bypass;
        or0 = 1'b1; iv0 = 1'b1; id0 = 32'h3C;
        #1;
        total++; if (ov0 !== 1'b1 || od0 !== 32'h3C) begin bad++; $display("FAIL byp_pass got=%b/%h want=1/3c", ov0, od0); end
        tick;
        total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL byp_pass_count got=%0d want=0", cnt0); end
        or0 = 1'b0; id0 = 32'hC3;
        #1;
        total++; if (od0 !== 32'hC3) begin bad++; $display("FAIL byp_comb_data got=%h want=c3", od0); end
        tick;
        iv0 = 1'b0; id0 = 32'h11;
        #1;
        total++; if (cnt0 !== 2'd1) begin bad++; $display("FAIL byp_hold_count got=%0d want=1", cnt0); end
        total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL byp_hold_ready got=%b want=0", ir0); end
        total++; if (ov0 !== 1'b1 || od0 !== 32'hC3) begin bad++; $display("FAIL byp_hold_data got=%b/%h want=1/c3", ov0, od0); end
        or0 = 1'b1;
        tick;
        total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL byp_drain_count got=%0d want=0", cnt0); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL byp_drain_ready got=%b want=1", ir0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL byp_drain_valid got=%b want=0", ov0); end
        or0 = 1'b0;
    endtask

    task automatic test_flush;
        or1 = 1'b0; or0 = 1'b0;
        iv1 = 1'b1; id1 = 32'h11; iv0 = 1'b1; id0 = 32'h44;
        tick;
        id1 = 32'h22; id0 = 32'h77;
        tick;
        total++; if (cnt1 !== 2'd2) begin bad++; $display("FAIL flush_pre_reg got=%0d want=2", cnt1); end
        total++; if (cnt0 !== 2'd1) begin bad++; $display("FAIL flush_pre_byp got=%0d want=1", cnt0); end
        id1 = 32'h77; flush = 1'b1;
        tick;
        flush = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
        #1;
        total++; if (cnt1 !== 2'd0 || ov1 !== 1'b0) begin bad++; $display("FAIL flush_full_reg got=%0d/%b want=0/0", cnt1, ov1); end
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL flush_ready_reg got=%b want=1", ir1); end
        total++; if (cnt0 !== 2'd0 || ov0 !== 1'b0 || ir0 !== 1'b1) begin bad++; $display("FAIL flush_byp got=%0d/%b/%b want=0/0/1", cnt0, ov0, ir0); end
        iv1 = 1'b1; id1 = 32'h88;
        tick;
        id1 = 32'h66; flush = 1'b1;
        tick;
        flush = 1'b0; iv1 = 1'b0;
        total++; if (cnt1 !== 2'd0 || ov1 !== 1'b0) begin bad++; $display("FAIL flush_accept_drop got=%0d/%b want=0/0", cnt1, ov1); end
        iv1 = 1'b1; id1 = 32'h99;
        tick;
        iv1 = 1'b0;
        total++; if (od1 !== 32'h99 || cnt1 !== 2'd1) begin bad++; $display("FAIL flush_after got=%h/%0d want=99/1", od1, cnt1); end
        or1 = 1'b1;
        tick;
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL flush_after_drain got=%b want=0", ov1); end
        or1 = 1'b0;
    endtask

    task automatic test_reset_mid;
        or1 = 1'b0; iv1 = 1'b1; id1 = 32'hE1;
        tick;
        id1 = 32'hE2;
        tick;
        iv1 = 1'b0;
        total++; if (cnt1 !== 2'd2) begin bad++; $display("FAIL rmid_pre got=%0d want=2", cnt1); end
        #2 rst = 1'b0;
        #1;
        total++; if (ir1 !== 1'b1 || ov1 !== 1'b0) begin bad++; $display("FAIL rmid_hs got=%b/%b want=1/0", ir1, ov1); end
        total++; if (cnt1 !== 2'd0 || od1 !== '0) begin bad++; $display("FAIL rmid_state got=%0d/%h want=0/0", cnt1, od1); end
        tick;
        rst = 1'b1; iv1 = 1'b1; id1 = 32'hF1; or1 = 1'b1;
        tick;
        iv1 = 1'b0;
        total++; if (ov1 !== 1'b1 || od1 !== 32'hF1 || cnt1 !== 2'd1) begin bad++; $display("FAIL rmid_restart got=%b/%h/%0d want=1/f1/1", ov1, od1, cnt1); end
        tick;
        total++; if (ov1 !== 1'b0 || cnt1 !== 2'd0) begin bad++; $display("FAIL rmid_clean got=%b/%0d want=0/0", ov1, cnt1); end
        or1 = 1'b0;
    endtask

    task automatic test_random;
        int n1 = 0, n0 = 0, cyc = 0;
        bit f1 = 1'b0, f0 = 1'b0;
        iv1 = 1'b0; iv0 = 1'b0;
        while ((n1 < 10000 || n0 < 10000) && cyc < 40000) begin
            tick;
            cyc++;
            if (!iv1 || f1) begin iv1 = ($urandom_range(3) != 0); id1 = $urandom; end
            if (!iv0 || f0) begin iv0 = ($urandom_range(3) != 0); id0 = $urandom; end
            or1 = ($urandom_range(3) != 0);
            or0 = ($urandom_range(3) != 0);
            #3;
            total++; if (cnt1 !== 2'(q1.size())) begin bad++; $display("FAIL rnd_count_reg cyc=%0d got=%0d want=%0d", cyc, cnt1, q1.size()); end
            total++; if (ir1 !== (q1.size() < 2)) begin bad++; $display("FAIL rnd_ready_reg cyc=%0d got=%b", cyc, ir1); end
            total++; if (ov1 !== (q1.size() > 0)) begin bad++; $display("FAIL rnd_valid_reg cyc=%0d got=%b", cyc, ov1); end
            if (q1.size() > 0) begin
                total++; if (od1 !== q1[0]) begin bad++; $display("FAIL rnd_data_reg cyc=%0d got=%h want=%h", cyc, od1, q1[0]); end
            end
            total++; if (cnt0 !== 2'(q0.size())) begin bad++; $display("FAIL rnd_count_byp cyc=%0d got=%0d want=%0d", cyc, cnt0, q0.size()); end
            total++; if (ir0 !== (q0.size() == 0)) begin bad++; $display("FAIL rnd_ready_byp cyc=%0d got=%b", cyc, ir0); end
            total++; if (ov0 !== (q0.size() > 0 || iv0)) begin bad++; $display("FAIL rnd_valid_byp cyc=%0d got=%b", cyc, ov0); end
            if (q0.size() > 0) begin
                total++; if (od0 !== q0[0]) begin bad++; $display("FAIL rnd_data_byp cyc=%0d got=%h want=%h", cyc, od0, q0[0]); end
            end else if (iv0) begin
                total++; if (od0 !== id0) begin bad++; $display("FAIL rnd_pass_byp cyc=%0d got=%h want=%h", cyc, od0, id0); end
            end
            f1 = iv1 && ir1;
            f0 = iv0 && ir0;
            if (ov1 && or1) n1++;
            if (ov0 && or0) n0++;
        end
        total++; if (n1 < 10000 || n0 < 10000) begin bad++; $display("FAIL rnd_budget got=%0d/%0d want=10000 each", n1, n0); end
        iv1 = 1'b0; iv0 = 1'b0; or1 = 1'b1; or0 = 1'b1;
        tick; tick; tick;
        total++; if (cnt1 !== 2'd0 || cnt0 !== 2'd0) begin bad++; $display("FAIL rnd_drain got=%0d/%0d want=0/0", cnt1, cnt0); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_bypass;
        test_flush;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_skid.md
# rv_skid

Parametrised two-entry skid buffer on a valid/ready channel. It breaks the combinational ready path between a producer and a consumer while sustaining one transfer per cycle. A build-time mode selects one of two variants:
- Fully registered output: ready, valid and data all from flops.
- Bypass: zero-latency data, only ready registered.

It also adds a synchronous flush and an occupancy output. It sits between any two valid/ready stages in the datapath and replaces the fixed 8-bit single-register skid stage.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- REG_OUT, 1, 1 = registered-output mode, 0 = bypass mode

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = in reset)
- flush  input  1  synchronous clear of all held entries
- in_valid  input  1  producer data valid
- in_ready  output  1  buffer can accept, driven from a flop in both modes
- in_data  input  DATA_W  producer payload
- out_valid  output  1  payload available to consumer
- out_ready  input  1  consumer accepts
- out_data  output  DATA_W  consumer payload
- count  output  2  entries held: 0, 1 or 2

## Operation
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - in_valid and in_data must hold stable until fire.
- REG_OUT=1: main register drives out_data; a skid register holds the overflow entry. State is EMPTY, BUSY or FULL.
  - EMPTY: input fire → main ← in_data → BUSY.
  - BUSY, input and output fire together: main ← in_data, stay BUSY.
  - BUSY, input fire only: skid ← in_data → FULL.
  - BUSY, output fire only: → EMPTY.
  - FULL: output fire → main ← skid → BUSY. in_ready=0 in FULL, so there is no input fire.
  - out_valid = (state≠EMPTY).
  - in_ready = (next state≠FULL), registered.
- REG_OUT=0: only the skid register is used. State is EMPTY or FULL (count 0/1).
  - out_valid = in_valid | FULL.
  - out_data = FULL ? skid : in_data.
  - in_ready = (state==EMPTY), registered.
  - EMPTY, input fire without out_ready → skid ← in_data → FULL.
  - FULL, output fire → EMPTY.
- flush=1:
  - State → EMPTY and count → 0 at the next edge.
  - flush dominates any same-cycle input or output fire. An input accepted in a flush cycle is discarded.
  - Data registers are not cleared by flush.
- Data order is strictly FIFO. No entry is duplicated or dropped, except by flush.

## Timing
- Reset values: state EMPTY, in_ready 1, out_valid 0, count 0.
- Reset value of main and skid data: all zeros. out_data reads 0 in REG_OUT=1; in REG_OUT=0 it follows in_data.
- Reset takes effect immediately, including mid-transfer. Held entries are lost. The first accept is possible on the first edge after rst deasserts.
- Latency:
  - REG_OUT=1: input fire at edge N → out_valid=1 from edge N (visible in the cycle after the accepting edge). One cycle, in_data to out_data.
  - REG_OUT=0: zero cycles; in_data appears on out_data in the same cycle.
- Throughput: one transfer per cycle in steady state when out_ready=1, in both modes.
- Backpressure: in_ready falls one edge after the buffer fills. It rises one edge after the output fire that frees an entry.
- count always equals the number of held entries. In REG_OUT=0, count never exceeds 1.

## Structure
- Package rv_skid_pkg holds:
  - typedef enum logic [1:0] skid_state_e {EMPTY, BUSY, FULL}
  - function skid_count(state) returning logic [1:0]
- Sub-module skid_reg: DATA_W-wide register with load enable and async active-low reset to 0. Instantiated for main (REG_OUT=1 only) and skid.
- Mode selection uses a generate block on REG_OUT. Only one FSM is elaborated per instance.

## Test plan
- Reset, then stream 0x01..0x10 with out_ready=1, REG_OUT=1: in_ready stays 1; out_data 0x01..0x10 in order, each one cycle after acceptance; count=1 throughout.
- REG_OUT=1, accept 0xA5 then 0x5A with out_ready=0: count 1 then 2; in_ready=0 after the second edge. Raise out_ready: 0xA5 then 0x5A emerge; in_ready returns to 1 one edge after the first output fire.
- REG_OUT=0, send 0x3C with out_ready=1: out_data=0x3C in the same cycle, count stays 0. Send 0xC3 with out_ready=0: skid holds it, count=1, in_ready=0. Raise out_ready: 0xC3 is delivered, then count=0.
- FULL state with flush=1 and in_valid=1 (0x77) in the same cycle: next edge count=0, out_valid=0, in_ready=1; 0x77 is never output.
- Assert rst mid-stream with count=2: outputs immediately go to their reset values. After release, the stream restarts cleanly with no stale data.
- Randomised valid/out_ready at DATA_W=32, both modes, 10k transfers: scoreboard shows in-order, loss-free delivery and count matches the model every cycle.
